// File: rtl/apb_slave_bfm_mem.sv
// apb_slave_bfm_mem: APB slave memory model with programmable wait states, range error and transfer counter.
// Define APB_SLAVE_BFM_PROTCHK_EN to build the sticky PROTERR protocol checker.
module apb_slave_bfm_mem #(
    parameter int AWIDTH = 8,
    parameter int TPD    = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  WAITSTATES,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [15:0] XFERCNT,
    output logic        PROTERR
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [15:0]       xfercnt_q, xfercnt_d;
    logic [31:0]       mem_q [2**AWIDTH] = '{default: 32'h0};
    logic [AWIDTH-1:0] idx;
    logic              oor, active, pready, pslverr, we, unused_paddr;
    logic [31:0]       prdata;

    // bits 31:24 belong to the bridge decode, bits 1:0 are byte lanes
    assign idx          = PADDR[AWIDTH+1:2];
    assign oor          = |PADDR[23:AWIDTH+2];
    assign unused_paddr = ^{PADDR[31:24], PADDR[1:0]};
    assign active       = state_q == ACCESS && PSEL && PENABLE;
    assign pready       = active && wait_q == 4'd0;
    assign pslverr      = pready && oor;
    assign we           = pready && PWRITE && !oor;
    assign prdata       = (active && !PWRITE && !oor) ? mem_q[idx] : 32'h0;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        xfercnt_d = xfercnt_q + {15'd0, pready && !oor};
        if (state_q == IDLE) begin
            state_d = (PSEL && !PENABLE) ? ACCESS : IDLE;
            wait_d  = (PSEL && !PENABLE) ? WAITSTATES : wait_q;
        end else if (!PSEL || pready) begin
            state_d = IDLE;
        end else if (PENABLE) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            xfercnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            xfercnt_q <= xfercnt_d;
        end
    end

    // memory is deliberately outside the reset domain
    always_ff @(posedge HCLK) begin
        if (HRESETN && we)
            mem_q[idx] <= PWDATA;
    end

    assign #TPD PRDATA  = prdata;
    assign #TPD PREADY  = pready;
    assign #TPD PSLVERR = pslverr;
    assign #TPD XFERCNT = xfercnt_q;

`ifdef APB_SLAVE_BFM_PROTCHK_EN
    logic        proterr_q, proterr_d, pwrite_q, pwrite_d, setup;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        viol_a, viol_b, viol_c;

    always_comb begin
        setup     = state_q == IDLE && PSEL && !PENABLE;
        viol_a    = state_q == IDLE && PSEL && PENABLE;
        viol_b    = state_q == ACCESS && PSEL &&
                    (PADDR != addr_q || PWRITE != pwrite_q || (pwrite_q && PWDATA != wdata_q));
        viol_c    = PENABLE && !PSEL;
        proterr_d = proterr_q || viol_a || viol_b || viol_c;
        addr_d    = setup ? PADDR : addr_q;
        pwrite_d  = setup ? PWRITE : pwrite_q;
        wdata_d   = setup ? PWDATA : wdata_q;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            proterr_q <= 1'b0;
            pwrite_q  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else begin
            proterr_q <= proterr_d;
            pwrite_q  <= pwrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            if (viol_a || viol_b || viol_c)
                $display("%0t apb_slave_bfm_mem protocol violation: no_setup=%0b unstable=%0b enable_wo_sel=%0b",
                         $time, viol_a, viol_b, viol_c);
        end
    end

    assign #TPD PROTERR = proterr_q;
`else
    assign #TPD PROTERR = 1'b0;
`endif
endmodule

// File: tb/tb_apb_slave_bfm_mem.sv
// tb_apb_slave_bfm_mem: directed scoreboard bench for apb_slave_bfm_mem (AWIDTH=8).
module tb_apb_slave_bfm_mem;
    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PADDR = 32'h0;
    logic [31:0] PWDATA = 32'h0;
    logic [3:0]  WAITSTATES = 4'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, PROTERR;
    logic [15:0] XFERCNT;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

`ifdef APB_SLAVE_BFM_PROTCHK_EN
    localparam logic EXP_PROTERR = 1'b1;
`else
    localparam logic EXP_PROTERR = 1'b0;
`endif

    always #5 HCLK = ~HCLK;

    apb_slave_bfm_mem #(.AWIDTH(8), .TPD(1)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .WAITSTATES(WAITSTATES), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .XFERCNT(XFERCNT), .PROTERR(PROTERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%h expected=entry", obs);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks--;
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic setup_phase(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #2;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge HCLK); #2;
        PENABLE = 1'b1;
    endtask

    // full transfer; WAITSTATES is scrambled after setup to show it is latched
    task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input bit exp_err);
        int waits;
        WAITSTATES = ws;
        push({name, "_waits"}, {28'd0, ws});
        push({name, "_prdata"}, exp_rd);
        push({name, "_pslverr"}, {31'd0, exp_err});
        setup_phase(wr, addr, data);
        WAITSTATES = ~ws;
        waits = 0;
        forever begin
            @(negedge HCLK);
            if (PREADY === 1'b1 || waits > 20) break;
            waits++;
        end
        pop_check(waits);
        pop_check(PRDATA);
        pop_check({31'd0, PSLVERR});
        @(posedge HCLK); #2;
        PSEL = 1'b0; PENABLE = 1'b0;
        WAITSTATES = ws;
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] exp);
        @(negedge HCLK);
        check(tag, {16'd0, XFERCNT}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge HCLK);
        #2 HRESETN = 1'b1;
        @(negedge HCLK);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_xfercnt", {16'd0, XFERCNT}, 32'd0);
        check("rst_proterr", {31'd0, PROTERR}, 32'd0);

        xfer("wr0", 1'b1, 32'h10, 32'hDEADBEEF, 4'd0, 32'h0, 1'b0);
        check_cnt("cnt_after_wr0", 16'd1);
        xfer("rd0", 1'b0, 32'h10, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0);
        check_cnt("cnt_after_rd0", 16'd2);
        xfer("rd_ws3", 1'b0, 32'h10, 32'h0, 4'd3, 32'hDEADBEEF, 1'b0);
        check_cnt("cnt_after_ws3", 16'd3);
        xfer("wr_oor", 1'b1, 32'h400, 32'h12345678, 4'd0, 32'h0, 1'b1);
        check_cnt("cnt_after_oor", 16'd3);
        xfer("rd_alias", 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0);
        check_cnt("cnt_after_alias", 16'd4);

        WAITSTATES = 4'd2;
        setup_phase(1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge HCLK);
        check("abort_pready_wait", {31'd0, PREADY}, 32'd0);
        @(posedge HCLK); #2;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        check("abort_pready_drop", {31'd0, PREADY}, 32'd0);
        check("abort_cnt", {16'd0, XFERCNT}, 32'd4);
        xfer("abort_rd", 1'b0, 32'h20, 32'h0, 4'd0, 32'h0, 1'b0);
        check_cnt("cnt_after_abort_rd", 16'd5);

        WAITSTATES = 4'd3;
        setup_phase(1'b0, 32'h10, 32'h0);
        @(negedge HCLK);
        check("rstacc_prdata_pre", PRDATA, 32'hDEADBEEF);
        check("rstacc_pready_pre", {31'd0, PREADY}, 32'd0);
        @(posedge HCLK); #2;
        HRESETN = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("rstacc_prdata", PRDATA, 32'd0);
        check("rstacc_pready", {31'd0, PREADY}, 32'd0);
        check("rstacc_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rstacc_xfercnt", {16'd0, XFERCNT}, 32'd0);
        @(posedge HCLK); #2;
        HRESETN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        xfer("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0);
        check_cnt("cnt_after_rst_rd", 16'd1);

        @(negedge HCLK);
        force dut.xfercnt_q = 16'hFFFE;
        #1 release dut.xfercnt_q;
        xfer("wrap_rd0", 1'b0, 32'h10, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0);
        check_cnt("cnt_ffff", 16'hFFFF);
        xfer("wrap_rd1", 1'b0, 32'h10, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0);
        check_cnt("cnt_wrap", 16'h0000);

        @(posedge HCLK); #2;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h10;
        @(negedge HCLK);
        check("noset_pready", {31'd0, PREADY}, 32'd0);
        check("noset_prdata", PRDATA, 32'd0);
        @(posedge HCLK); #2;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK);
        check("proterr_set", {31'd0, PROTERR}, {31'd0, EXP_PROTERR});
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("proterr_sticky", {31'd0, PROTERR}, {31'd0, EXP_PROTERR});
        check("noset_cnt", {16'd0, XFERCNT}, 32'd0);
        @(posedge HCLK); #2;
        HRESETN = 1'b0;
        @(posedge HCLK); #2;
        HRESETN = 1'b1;
        @(negedge HCLK);
        check("proterr_cleared", {31'd0, PROTERR}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
